// File: rtl/segre_pkg.sv
// Shared memory-op types and byte-lane helpers for the LSU / store buffer slice.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package segre_pkg;

  localparam int ADDR_SIZE = 32;
  localparam int WORD_SIZE = 32;
  localparam int BE_W      = WORD_SIZE / 8;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;

  // Byte enables of an access inside its word; misalignment is not checked here.
  function automatic logic [BE_W-1:0] memop_byte_en(memop_data_type_e t, logic [1:0] off);
    logic [BE_W-1:0] be;
    case (t)
      BYTE:    be = 4'b0001 << off;
      HALF:    be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Move right-justified store data onto the byte lanes selected by the offset.
  function automatic logic [WORD_SIZE-1:0] memop_align_data(logic [WORD_SIZE-1:0] d, logic [1:0] off);
    return d << {off, 3'b000};
  endfunction

  // Keeps only the low bytes that belong to an access of the given size.
  function automatic logic [WORD_SIZE-1:0] memop_size_mask(memop_data_type_e t);
    logic [WORD_SIZE-1:0] m;
    case (t)
      BYTE:    m = 32'h0000_00FF;
      HALF:    m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/segre_sb_fwd_unit.sv
// Store-buffer load lookup: youngest matching entry, byte coverage check, data extract.
// Latency: purely combinational on the registered entry state.
// Backpressure: none; conflict output tells the LSU to stall the load.
module segre_sb_fwd_unit
  import segre_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int WADDR_W = 30,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]     entry_vld,
  input  logic [WADDR_W-1:0]   entry_waddr [DEPTH],
  input  logic [WORD_SIZE-1:0] entry_data  [DEPTH],
  input  logic [BE_W-1:0]      entry_mask  [DEPTH],
  input  logic [PTR_W-1:0]     head,
  input  logic [WADDR_W-1:0]   lookup_waddr,
  input  logic [1:0]           lookup_off,
  input  memop_data_type_e     lookup_type,
  output logic                 hit,
  output logic                 conflict,
  output logic [WORD_SIZE-1:0] fwd_data
);

  logic [BE_W-1:0]      lookup_be;
  logic                 match;
  logic [PTR_W-1:0]     match_idx;
  logic                 covered;
  logic [WORD_SIZE-1:0] shifted;

  assign lookup_be = memop_byte_en(lookup_type, lookup_off);

  // Walk slots oldest-to-youngest starting at head so the last match seen is the youngest.
  always_comb begin
    logic [PTR_W-1:0] slot;
    slot      = '0;
    match     = 1'b0;
    match_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head + PTR_W'(k);
      if (entry_vld[slot] && (entry_waddr[slot] == lookup_waddr)) begin
        match     = 1'b1;
        match_idx = slot;
      end
    end
  end

  // Only the youngest entry decides coverage; older copies are never mixed in.
  always_comb begin
    covered  = match && ((entry_mask[match_idx] & lookup_be) == lookup_be);
    shifted  = entry_data[match_idx] >> {lookup_off, 3'b000};
    hit      = covered;
    conflict = match && !covered;
    fwd_data = covered ? (shifted & memop_size_mask(lookup_type)) : '0;
  end

endmodule

// File: rtl/segre_store_buffer_param.sv
// Coalescing store buffer between LSU and D$: per-byte masks, load forwarding, in-order drain.
// Latency: store visible to loads and drain one cycle after acceptance; lookup is combinational.
// Backpressure: store_ready_o low when full without a merge or during drain-all; drain waits on drain_ready_i.
module segre_store_buffer_param
  import segre_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int ADDR_W          = ADDR_SIZE,
  parameter int DRAIN_THRESHOLD = DEPTH - 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       store_valid_i,
  output logic                       store_ready_o,
  input  logic [ADDR_W-1:0]          store_addr_i,
  input  logic [WORD_SIZE-1:0]       store_data_i,
  input  memop_data_type_e           store_type_i,
  input  logic                       load_valid_i,
  input  logic [ADDR_W-1:0]          load_addr_i,
  input  memop_data_type_e           load_type_i,
  output logic                       fwd_hit_o,
  output logic                       fwd_conflict_o,
  output logic [WORD_SIZE-1:0]       fwd_data_o,
  input  logic                       drain_en_i,
  input  logic                       drain_all_i,
  output logic                       drain_valid_o,
  input  logic                       drain_ready_i,
  output logic [ADDR_W-1:0]          drain_addr_o,
  output logic [WORD_SIZE-1:0]       drain_data_o,
  output logic [BE_W-1:0]            drain_be_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WA_W  = ADDR_W - 2;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] THR_CNT  = CNT_W'(DRAIN_THRESHOLD);

  logic [DEPTH-1:0]     vld_q;
  logic [WA_W-1:0]      waddr_q [DEPTH];
  logic [WORD_SIZE-1:0] data_q  [DEPTH];
  logic [BE_W-1:0]      mask_q  [DEPTH];
  logic [PTR_W-1:0]     head_q, tail_q;
  logic [CNT_W-1:0]     count_q, count_nxt;
  logic                 pend_q, pend_nxt;

  logic [WA_W-1:0]      st_waddr;
  logic [BE_W-1:0]      st_be;
  logic [WORD_SIZE-1:0] st_data;
  logic                 drain_vld;
  logic                 co_hit;
  logic [PTR_W-1:0]     co_idx;
  logic                 ready_int, accept, merge, alloc, pop;
  logic                 lu_hit, lu_conflict;
  logic [WORD_SIZE-1:0] lu_data;
  logic                 ld_en;

  assign st_waddr = store_addr_i[ADDR_W-1:2];
  assign st_be    = memop_byte_en(store_type_i, store_addr_i[1:0]);
  assign st_data  = memop_align_data(store_data_i, store_addr_i[1:0]);

  assign drain_vld = (count_q != '0) && (drain_en_i || (count_q >= THR_CNT) || pend_q);

  // Coalesce into the youngest same-word entry; the tail is off limits while it is on the drain port.
  always_comb begin
    logic [PTR_W-1:0] slot;
    slot   = '0;
    co_hit = 1'b0;
    co_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_q + PTR_W'(k);
      if (vld_q[slot] && (waddr_q[slot] == st_waddr) && !(drain_vld && (slot == tail_q))) begin
        co_hit = 1'b1;
        co_idx = slot;
      end
    end
  end

  // Handshake decode; a same-cycle pop never frees a slot for allocation.
  always_comb begin
    ready_int = !pend_q && (co_hit || (count_q < FULL_CNT));
    accept    = store_valid_i && ready_int;
    merge     = accept && co_hit;
    alloc     = accept && !co_hit;
    pop       = drain_vld && drain_ready_i;
    count_nxt = count_q + CNT_W'(alloc) - CNT_W'(pop);
    if (count_nxt == '0) begin
      pend_nxt = 1'b0;
    end else if (drain_all_i && (count_q != '0)) begin
      pend_nxt = 1'b1;
    end else begin
      pend_nxt = pend_q;
    end
  end

  // Entry array and pointer updates; pop and allocate always touch different slots.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pend_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        waddr_q[i] <= '0;
        data_q[i]  <= '0;
        mask_q[i]  <= '0;
      end
    end else begin
      if (pop) begin
        vld_q[tail_q] <= 1'b0;
        tail_q        <= tail_q + PTR_W'(1);
      end
      if (merge) begin
        for (int b = 0; b < BE_W; b++) begin
          if (st_be[b]) begin
            data_q[co_idx][8*b +: 8] <= st_data[8*b +: 8];
          end
        end
        mask_q[co_idx] <= mask_q[co_idx] | st_be;
      end
      if (alloc) begin
        vld_q[head_q]   <= 1'b1;
        waddr_q[head_q] <= st_waddr;
        data_q[head_q]  <= st_data;
        mask_q[head_q]  <= st_be;
        head_q          <= head_q + PTR_W'(1);
      end
      count_q <= count_nxt;
      pend_q  <= pend_nxt;
    end
  end

  segre_sb_fwd_unit #(
    .DEPTH   (DEPTH),
    .WADDR_W (WA_W),
    .PTR_W   (PTR_W)
  ) u_fwd (
    .entry_vld    (vld_q),
    .entry_waddr  (waddr_q),
    .entry_data   (data_q),
    .entry_mask   (mask_q),
    .head         (head_q),
    .lookup_waddr (load_addr_i[ADDR_W-1:2]),
    .lookup_off   (load_addr_i[1:0]),
    .lookup_type  (load_type_i),
    .hit          (lu_hit),
    .conflict     (lu_conflict),
    .fwd_data     (lu_data)
  );

  // Outputs are forced quiet while reset is held.
  always_comb begin
    ld_en          = load_valid_i && !rst_i;
    store_ready_o  = !rst_i && ready_int;
    fwd_hit_o      = ld_en && lu_hit;
    fwd_conflict_o = ld_en && lu_conflict;
    fwd_data_o     = ld_en ? lu_data : '0;
    drain_valid_o  = !rst_i && drain_vld;
    drain_addr_o   = rst_i ? '0 : {waddr_q[tail_q], 2'b00};
    drain_data_o   = rst_i ? '0 : data_q[tail_q];
    drain_be_o     = rst_i ? '0 : mask_q[tail_q];
    count_o        = rst_i ? '0 : count_q;
    empty_o        = rst_i || (count_q == '0);
  end

endmodule

// File: tb/tb_segre_store_buffer_param.sv
// Bench for segre_store_buffer_param: directed table, hand sequences, randomized run vs queue model.
module tb_segre_store_buffer_param;
  import segre_pkg::*;

  localparam int DEPTH = 4;
  localparam int THR   = 3;
  localparam int AW    = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             store_valid, store_ready;
  logic [AW-1:0]    store_addr;
  logic [31:0]      store_data;
  memop_data_type_e store_type;
  logic             load_valid;
  logic [AW-1:0]    load_addr;
  memop_data_type_e load_type;
  logic             fwd_hit, fwd_conflict;
  logic [31:0]      fwd_data;
  logic             drain_en, drain_all, drain_valid, drain_ready;
  logic [AW-1:0]    drain_addr;
  logic [31:0]      drain_data;
  logic [3:0]       drain_be;
  logic [2:0]       count;
  logic             empty;

  segre_store_buffer_param #(.DEPTH(DEPTH), .ADDR_W(AW), .DRAIN_THRESHOLD(THR)) dut (
    .clk_i(clk), .rst_i(rst),
    .store_valid_i(store_valid), .store_ready_o(store_ready), .store_addr_i(store_addr),
    .store_data_i(store_data), .store_type_i(store_type),
    .load_valid_i(load_valid), .load_addr_i(load_addr), .load_type_i(load_type),
    .fwd_hit_o(fwd_hit), .fwd_conflict_o(fwd_conflict), .fwd_data_o(fwd_data),
    .drain_en_i(drain_en), .drain_all_i(drain_all), .drain_valid_o(drain_valid),
    .drain_ready_i(drain_ready), .drain_addr_o(drain_addr), .drain_data_o(drain_data),
    .drain_be_o(drain_be), .count_o(count), .empty_o(empty)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: ordered list of buffered words ----------------
  typedef struct {
    logic [29:0] wa;
    logic [31:0] data;
    logic [3:0]  mask;
  } ment_t;

  ment_t q[$];
  bit    m_pend = 1'b0;

  function automatic logic [3:0] be_of(memop_data_type_e t, logic [1:0] off);
    if (t == BYTE) return 4'(1 << off);
    if (t == HALF) return off[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] lanes(logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = m[b] ? 8'hFF : 8'h00;
    return r;
  endfunction

  function automatic bit m_dv();
    return (q.size() > 0) && (drain_en || (q.size() >= THR) || m_pend);
  endfunction

  function automatic int m_coal();
    int lo;
    lo = m_dv() ? 1 : 0;
    for (int j = q.size() - 1; j >= lo; j--)
      if (q[j].wa == store_addr[31:2]) return j;
    return -1;
  endfunction

  function automatic bit m_ready();
    return !m_pend && ((m_coal() >= 0) || (q.size() < DEPTH));
  endfunction

  task automatic model_check();
    logic        eh, ec;
    logic [31:0] ed, szm;
    logic [3:0]  lbe;
    if (rst) begin
      chk("rst_store_ready", store_ready, 0);
      chk("rst_drain_valid", drain_valid, 0);
      chk("rst_fwd_hit", fwd_hit, 0);
      chk("rst_fwd_conflict", fwd_conflict, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_drain_be", drain_be, 0);
      return;
    end
    chk("m_store_ready", store_ready, m_ready());
    chk("m_drain_valid", drain_valid, m_dv());
    chk("m_count", count, q.size());
    chk("m_empty", empty, q.size() == 0);
    if (m_dv()) begin
      chk("m_drain_addr", drain_addr, {q[0].wa, 2'b00});
      chk("m_drain_be", drain_be, q[0].mask);
      chk("m_drain_data", drain_data & lanes(q[0].mask), q[0].data & lanes(q[0].mask));
    end
    eh = 0; ec = 0; ed = 0;
    if (load_valid) begin
      lbe = be_of(load_type, load_addr[1:0]);
      szm = (load_type == BYTE) ? 32'hFF : (load_type == HALF) ? 32'hFFFF : 32'hFFFF_FFFF;
      for (int j = q.size() - 1; j >= 0; j--) begin
        if (q[j].wa == load_addr[31:2]) begin
          if ((q[j].mask & lbe) == lbe) begin
            eh = 1;
            ed = (q[j].data >> (8 * load_addr[1:0])) & szm;
          end else begin
            ec = 1;
          end
          break;
        end
      end
    end
    chk("m_fwd_hit", fwd_hit, eh);
    chk("m_fwd_conflict", fwd_conflict, ec);
    chk("m_fwd_data", fwd_data, ed);
  endtask

  task automatic model_update();
    int          pre, j;
    bit          acc, pop;
    logic [3:0]  be;
    logic [31:0] al;
    ment_t       e;
    if (rst) begin
      q.delete();
      m_pend = 0;
      return;
    end
    pre = q.size();
    j   = m_coal();
    acc = store_valid && m_ready();
    pop = m_dv() && drain_ready;
    be  = be_of(store_type, store_addr[1:0]);
    al  = store_data << (8 * store_addr[1:0]);
    if (acc && j >= 0) begin
      e = q[j];
      for (int b = 0; b < 4; b++) if (be[b]) e.data[8*b +: 8] = al[8*b +: 8];
      e.mask = e.mask | be;
      q[j] = e;
    end
    if (pop) void'(q.pop_front());
    if (acc && j < 0) begin
      e.wa = store_addr[31:2];
      e.data = al;
      e.mask = be;
      q.push_back(e);
    end
    if (q.size() == 0) m_pend = 0;
    else if (drain_all && pre != 0) m_pend = 1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic at_pos();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    store_valid = 0; store_addr = 0; store_data = 0; store_type = WORD;
    load_valid = 0; load_addr = 0; load_type = WORD;
    drain_en = 0; drain_all = 0; drain_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    at_neg(); at_pos();
    at_neg(); at_pos();
    rst = 0;
  endtask

  task automatic put_store(logic [31:0] a, logic [31:0] d, memop_data_type_e t);
    store_valid = 1; store_addr = a; store_data = d; store_type = t;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic             sv;
    logic [31:0]      sa;
    logic [31:0]      sd;
    memop_data_type_e st;
    logic             lv;
    logic [31:0]      la;
    memop_data_type_e lt;
    logic             eh;
    logic             ec;
    logic [31:0]      ed;
    int               ecnt;
    logic [3:0]       ebe;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b1, 32'h1000, 32'hDEADBEEF, WORD, 1'b0, 32'h0,    WORD, 1'b0, 1'b0, 32'h0,        0, 4'h0};
    tbl[1] = '{1'b0, 32'h0,    32'h0,        WORD, 1'b1, 32'h1000, WORD, 1'b1, 1'b0, 32'hDEADBEEF, 1, 4'hF};
    tbl[2] = '{1'b1, 32'h1001, 32'h000000AA, BYTE, 1'b0, 32'h0,    WORD, 1'b0, 1'b0, 32'h0,        1, 4'hF};
    tbl[3] = '{1'b0, 32'h0,    32'h0,        WORD, 1'b1, 32'h1000, WORD, 1'b1, 1'b0, 32'hDEADAAEF, 1, 4'hF};
    tbl[4] = '{1'b1, 32'h2002, 32'h00000055, BYTE, 1'b0, 32'h0,    WORD, 1'b0, 1'b0, 32'h0,        1, 4'hF};
    tbl[5] = '{1'b0, 32'h0,    32'h0,        WORD, 1'b1, 32'h2000, WORD, 1'b0, 1'b1, 32'h0,        2, 4'hF};
    tbl[6] = '{1'b0, 32'h0,    32'h0,        WORD, 1'b1, 32'h2002, BYTE, 1'b1, 1'b0, 32'h55,       2, 4'hF};
    tbl[7] = '{1'b0, 32'h0,    32'h0,        WORD, 1'b1, 32'h3000, WORD, 1'b0, 1'b0, 32'h0,        2, 4'hF};
    tbl[8] = '{1'b0, 32'h0,    32'h0,        WORD, 1'b1, 32'h1002, HALF, 1'b1, 1'b0, 32'hDEAD,     2, 4'hF};

    idle_inputs();
    do_reset();

    // Table: each row's load sees the state before that row's store.
    for (int i = 0; i < 9; i++) begin
      idle_inputs();
      store_valid = tbl[i].sv; store_addr = tbl[i].sa; store_data = tbl[i].sd; store_type = tbl[i].st;
      load_valid = tbl[i].lv; load_addr = tbl[i].la; load_type = tbl[i].lt;
      at_neg();
      chk($sformatf("tbl%0d_hit", i), fwd_hit, tbl[i].eh);
      chk($sformatf("tbl%0d_conflict", i), fwd_conflict, tbl[i].ec);
      chk($sformatf("tbl%0d_data", i), fwd_data, tbl[i].ed);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].ecnt);
      chk($sformatf("tbl%0d_be", i), drain_be, tbl[i].ebe);
      at_pos();
    end

    // Threshold drain, full back-pressure and merge-while-full.
    idle_inputs();
    do_reset();
    put_store(32'h0, 32'h11111111, WORD); at_neg(); at_pos();
    put_store(32'h4, 32'h22222222, WORD); at_neg(); at_pos();
    put_store(32'h8, 32'h33333333, WORD); at_neg(); at_pos();
    store_valid = 0;
    at_neg();
    chk("thr_count", count, 3);
    chk("thr_drain_valid", drain_valid, 1);
    chk("thr_drain_addr", drain_addr, 32'h0);
    at_pos();
    put_store(32'hC, 32'h44444444, WORD); at_neg(); chk("fill_ready", store_ready, 1); at_pos();
    put_store(32'h10, 32'h55555555, WORD);
    at_neg();
    chk("full_count", count, 4);
    chk("full_ready", store_ready, 0);
    at_pos();
    put_store(32'h4, 32'h000000EE, BYTE); at_neg(); chk("full_merge_ready", store_ready, 1); at_pos();
    store_valid = 0; load_valid = 1; load_addr = 32'h4; load_type = WORD;
    at_neg();
    chk("merge_count", count, 4);
    chk("merge_fwd", fwd_data, 32'h222222EE);
    chk("stall_drain_addr", drain_addr, 32'h0);
    chk("stall_drain_data", drain_data, 32'h11111111);
    at_pos();

    // Drain-all fence with a store held on the input.
    idle_inputs();
    do_reset();
    put_store(32'h40, 32'h1, WORD); at_neg(); at_pos();
    put_store(32'h44, 32'h2, WORD); at_neg(); at_pos();
    put_store(32'h48, 32'h3, WORD); at_neg(); at_pos();
    put_store(32'h50, 32'h4, WORD); drain_all = 1;
    at_neg(); chk("fence_pulse_ready", store_ready, 1); at_pos();
    drain_all = 0; drain_ready = 1;
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk($sformatf("fence_ready_k%0d", k), store_ready, k >= 4);
      chk($sformatf("fence_count_k%0d", k), count, 4 - k);
      at_pos();
    end
    idle_inputs();

    // Reset while an entry is on the drain port.
    do_reset();
    drain_en = 1;
    put_store(32'h80, 32'hCAFE, WORD); at_neg(); at_pos();
    store_valid = 0;
    at_neg(); chk("pre_rst_drain_valid", drain_valid, 1); at_pos();
    rst = 1; drain_ready = 1;
    at_neg(); at_pos();
    rst = 0; drain_ready = 0;
    at_neg();
    chk("post_rst_count", count, 0);
    chk("post_rst_drain_valid", drain_valid, 0);
    at_pos();

    // Randomized traffic over a small address pool so coalescing, wrap and stalls all occur.
    idle_inputs();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      int unsigned t;
      store_valid = ($urandom_range(0, 3) != 0);
      t = $urandom_range(0, 2);
      store_type = memop_data_type_e'(t);
      store_addr = 32'h100 + 4 * $urandom_range(0, 5);
      if (store_type == HALF) store_addr[1:0] = {1'($urandom_range(0, 1)), 1'b0};
      if (store_type == BYTE) store_addr[1:0] = 2'($urandom_range(0, 3));
      store_data = $urandom;
      load_valid = ($urandom_range(0, 1) != 0);
      t = $urandom_range(0, 2);
      load_type = memop_data_type_e'(t);
      load_addr = 32'h100 + 4 * $urandom_range(0, 5);
      if (load_type == HALF) load_addr[1:0] = {1'($urandom_range(0, 1)), 1'b0};
      if (load_type == BYTE) load_addr[1:0] = 2'($urandom_range(0, 3));
      drain_en    = ($urandom_range(0, 2) == 0);
      drain_ready = ($urandom_range(0, 1) != 0);
      drain_all   = ($urandom_range(0, 24) == 0);
      at_neg();
      at_pos();
    end

    idle_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/segre_store_buffer_param.md
Name: segre_store_buffer_param

Overview:
Parametrised store buffer that sits between the LSU and the data cache. It holds DEPTH word-granular entries with per-byte masks and coalesces stores to the same word. It forwards fully covered load bytes and flags partially covered loads so the LSU can stall. It drains entries oldest-first to the cache over a valid/ready handshake, either opportunistically, on a fill threshold, or on a forced drain-all.

Parameters:
DEPTH, 4, number of entries; power of two, at least 2
ADDR_W, ADDR_SIZE, byte address width
DRAIN_THRESHOLD, DEPTH-1, occupancy at or above which draining starts without drain_en_i

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
store_valid_i  in  1  store request
store_ready_o  out  1  store accepted this cycle when store_valid_i is also high
store_addr_i  in  ADDR_W  store byte address
store_data_i  in  WORD_SIZE  store data, right-justified
store_type_i  in  memop_data_type_e  BYTE/HALF/WORD
load_valid_i  in  1  load lookup request
load_addr_i  in  ADDR_W  load byte address
load_type_i  in  memop_data_type_e  load size
fwd_hit_o  out  1  every load byte is supplied by the buffer
fwd_conflict_o  out  1  load partially overlaps buffered bytes; LSU must stall
fwd_data_o  out  WORD_SIZE  forwarded bytes, right-justified, upper bits zero
drain_en_i  in  1  cache idle; drain allowed
drain_all_i  in  1  pulse; empty the buffer completely (fence)
drain_valid_o  out  1  tail entry presented to the cache
drain_ready_i  in  1  cache accepts the tail entry
drain_addr_o  out  ADDR_W  tail word address, bits [1:0] = 0
drain_data_o  out  WORD_SIZE  tail data
drain_be_o  out  WORD_SIZE/8  tail byte mask
count_o  out  $clog2(DEPTH+1)  occupancy
empty_o  out  1  count_o == 0

Behaviour:
- Entry contents: valid, word address (addr[ADDR_W-1:2]), data, byte mask. head and tail are $clog2(DEPTH)-bit pointers that wrap modulo DEPTH. count is held separately, so full and empty are unambiguous.
- Byte enables:
  - BYTE: bit addr[1:0].
  - HALF: bits {addr[1],0} and {addr[1],1}.
  - WORD: all four bits.
  - Data lanes are shifted to match the enables. Misaligned accesses are the LSU's responsibility; the buffer does not check them.
- Coalesce target: a valid entry whose word address matches store_addr_i. Excluded: the tail entry while drain_valid_o is high.
- Store:
  - On a coalesce hit, merge under the mask: new bytes overwrite, mask |= enables, count unchanged.
  - Otherwise allocate at head: data and mask written, valid set, head+1, count+1.
  - Takes effect at the next clock edge.
- store_ready_o = !drain_all_pending && (coalesce hit || count < DEPTH). A pop in the same cycle does not free a slot for allocation.
- Load lookup is combinational on registered state. A store in the same cycle is not visible to it.
  - Match selection: the youngest valid matching entry (nearest head). Two same-address entries can exist after a blocked tail coalesce.
  - Youngest mask covers all load enables: fwd_hit_o = 1.
  - Any match but not covered: fwd_conflict_o = 1 and fwd_hit_o = 0.
  - No match: both 0.
  - All fwd outputs are 0 when load_valid_i = 0.
- Drain:
  - drain_valid_o = count > 0 && (drain_en_i || count >= DRAIN_THRESHOLD || drain_all_pending).
  - Outputs are stable while drain_valid_o && !drain_ready_i.
  - Pop on valid && ready: valid cleared, tail+1, count-1.
- Simultaneous pop and allocate: count unchanged. When count == 1, a pop and an allocate may target different slots in the same cycle.
- drain_all_i sets drain_all_pending. It is cleared on the cycle the buffer becomes empty. If already empty, the pulse is ignored.
- Reset:
  - Clears all valid bits, head, tail, count and drain_all_pending.
  - While rst_i is high: all outputs are 0 except empty_o = 1.
  - Reset mid-handshake discards the presented entry.

Decomposition:
- segre_pkg gets a function memop_byte_en(memop_data_type_e, logic[1:0]) and a function for aligning data lanes.
- memop_data_type_e is reused unchanged.
- One sub-module: segre_sb_fwd_unit, the combinational youngest-match select and coverage check. It is parametrised by DEPTH and takes the entry arrays plus head.

Test Plan:
1. Reset, drain_en_i = 0; store WORD 0x1000 / 0xDEADBEEF; load WORD 0x1000 -> fwd_hit_o = 1, fwd_data_o = 0xDEADBEEF, count_o = 1.
2. Then store BYTE 0x1001 / 0xAA -> count_o stays 1; load WORD 0x1000 -> 0xDEADAAEF; drain_be_o = 4'b1111.
3. Store BYTE 0x2002 / 0x55:
   - Load WORD 0x2000 -> fwd_conflict_o = 1, fwd_hit_o = 0.
   - Load BYTE 0x2002 -> fwd_hit_o = 1, data 0x00000055.
   - Load 0x3000 -> both 0.
4. DEPTH = 4, drain disabled:
   - Stores to 0x0, 0x4, 0x8 -> drain_valid_o rises at count_o = 3 (threshold).
   - Hold drain_ready_i = 0 and store 0xC -> count_o = 4.
   - Store to 0x10 -> store_ready_o = 0.
   - Store to 0x4 -> store_ready_o = 1 (merge).
5. Toggle drain_ready_i randomly across 10 allocate/pop cycles -> drain_addr_o order equals allocation order across pointer wrap; a stalled drain holds its outputs stable; simultaneous pop + allocate keeps count_o.
6. Three entries, pulse drain_all_i with store_valid_i held -> store_ready_o = 0 until empty_o = 1, then 1. Separately, assert rst_i during drain_valid_o -> next cycle count_o = 0, drain_valid_o = 0.
